pixel_framebuffer: RTL
======================

# pixel_framebuffer

Pixel sink and colour source for the snake game's drawing interface. It accepts the backend's `plot`/`x`/`y`/`colour` pixel writes into a 160x120x3-bit frame store. It answers the colour lookups the movement FSM uses for collision and food detection. It streams the stored frame in raster order to the display side over a valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, default 160: pixels per row.
- `HEIGHT`, default 120: rows per frame.

Ports:
- `clk`, in, 1: sole clock.
- `rst`, in, 1: synchronous, active-high reset.
- `plot`, in, 1: write strobe, one pixel per cycle.
- `x_in`, in, 8: write column.
- `y_in`, in, 7: write row.
- `colour_in`, in, 3: write colour.
- `rd_en`, in, 1: lookup request.
- `rd_x`, in, 8: lookup column.
- `rd_y`, in, 7: lookup row.
- `rd_valid`, out, 1: lookup result valid.
- `rd_colour`, out, 3: lookup result, feeds the backend's `colour_in`.
- `oob`, out, 1: sticky flag; an out-of-range write or lookup occurred since reset.
- `scan_ready`, in, 1: display accepts a pixel.
- `scan_valid`, out, 1: scan pixel present.
- `scan_x`, out, 8: scan pixel column.
- `scan_y`, out, 7: scan pixel row.
- `scan_colour`, out, 3: scan pixel colour.
- `scan_sof`, out, 1: asserted with pixel (0,0).
- `clear_req`, in, 1: start a fill-to-black. Present only with `FB_CLEAR_EN`.
- `clear_busy`, out, 1: fill in progress. Present only with `FB_CLEAR_EN`.
- `clear_done`, out, 1: one-cycle pulse at fill end. Present only with `FB_CLEAR_EN`.

## Operation
- Address = y*160 + x, computed as (y<<7)+(y<<5)+x, 15 bits wide. 19200 entries.
- Storage is dual-port:
  - Port A serves writes, lookups and clear.
  - Port B serves scan-out only.
- Write: on a `plot` cycle with x<160 and y<120, store `colour_in`.
  - Out-of-range write is dropped and sets `oob`.
- Lookup: `rd_en` is sampled and the result returned one cycle later.
  - Out-of-range lookup returns 3'b000 and sets `oob`.
- Write and lookup in the same cycle:
  - Both are performed.
  - At the same address, the lookup returns the old value (read-before-write).
- Scan-out:
  - Raster counter runs x 0..159, then y 0..119.
  - After (159,119) it wraps to (0,0).
  - The counter advances only on a transfer (`scan_valid` && `scan_ready`).
  - Output uses a registered stage plus a one-entry skid so back-pressure never loses or repeats a pixel.
  - `scan_x`, `scan_y` and `scan_sof` stay aligned with `scan_colour`.
- Scan states:
  - FILL: after reset, priming the read.
  - STREAM: data presented.
  - No idle state; scan-out runs continuously.
- Memory contents are not reset and are undefined until written or cleared.

## Timing
- Reset values:
  - `rd_valid`, `rd_colour`, `oob`, `scan_valid`, `scan_x`, `scan_y`, `scan_colour`, `scan_sof` are all 0.
  - `clear_busy` and `clear_done` are 0.
  - Scan counter is at (0,0).
- Lookup latency: exactly 1 cycle. `rd_valid` = `rd_en` delayed by 1. A lookup can be issued every cycle.
- Write visibility:
  - A write in cycle N is visible to a lookup issued in cycle N+1.
  - It is visible to scan-out on the next pass over that pixel, provided the read of that pixel is issued after cycle N.
- Scan: first `scan_valid` rises 2 cycles after `rst` deasserts, carrying pixel (0,0) with `scan_sof`=1.
- With `scan_ready` held high, throughput is 1 pixel per cycle.
- `scan_valid` never drops while holding an unaccepted pixel. Outputs hold stable while `scan_valid` && !`scan_ready`.
- Reset mid-operation:
  - All of the above return to reset values on the next edge.
  - An in-flight lookup is discarded (no `rd_valid`).

## Configuration
- `FB_CLEAR_EN` defined: the clear engine is present.
  - `clear_req` is accepted when `clear_busy`=0. `clear_busy` rises the next cycle.
  - Port A then writes 0 to addresses 0..19199, one per cycle, for 19200 cycles.
  - `clear_busy` falls and `clear_done` pulses for one cycle after the last write.
  - While busy:
    - `plot` is dropped.
    - Lookups still return `rd_valid` after 1 cycle, with `rd_colour`=0.
    - `clear_req` is ignored.
    - Scan continues, showing partly cleared contents.
  - `rst` during a clear aborts it: `clear_busy`=0, no `clear_done`, and the memory is left partially cleared.
- `FB_CLEAR_EN` undefined: the clear ports and logic are absent, and port A serves only writes and lookups.

## Test plan
- Write (5,7) colour 3'b101, then lookup (5,7) on the next cycle -> `rd_valid`=1 and `rd_colour`=3'b101 one cycle later.
- Same cycle: write (10,10)=3'b010 over an old value of 3'b111 and lookup (10,10) -> returns 3'b111. A lookup next cycle returns 3'b010.
- Write (160,0) and lookup (0,120) -> no store, `rd_colour`=0, `oob`=1 until reset.
- `scan_ready` toggles in a pseudo-random pattern over 2 frames -> the accepted stream is exactly 19200 pixels per frame in raster order, `scan_sof` appears only at (0,0), no pixel is dropped or duplicated, and colours match the written pattern.
- `FB_CLEAR_EN`: fill the frame with 3'b111, then pulse `clear_req` -> `clear_busy` is high for 19200 cycles, then `clear_done` pulses once and every lookup returns 0. A `plot` issued mid-clear is not stored.
- `FB_CLEAR_EN`: assert `rst` 500 cycles into a clear -> next cycle `clear_busy`=0, `scan_valid`=0 and the scan restarts from (0,0). Address 499 reads 0 and address 600 reads 3'b111.

Source files
------------

// File: rtl/pixel_framebuffer.sv
// 160x120x3-bit frame store: pixel writes and 1-cycle colour lookups on port A, raster scan-out on port B.
// Optional fill-to-black engine is compiled in when FB_CLEAR_EN is defined.
module pixel_framebuffer #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic       clk,
    input  logic       rst,
`ifdef FB_CLEAR_EN
    input  logic       clear_req,
    output logic       clear_busy,
    output logic       clear_done,
`endif
    input  logic       plot,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] colour_in,
    input  logic       rd_en,
    input  logic [7:0] rd_x,
    input  logic [6:0] rd_y,
    output logic       rd_valid,
    output logic [2:0] rd_colour,
    output logic       oob,
    input  logic       scan_ready,
    output logic       scan_valid,
    output logic [7:0] scan_x,
    output logic [6:0] scan_y,
    output logic [2:0] scan_colour,
    output logic       scan_sof
);

    localparam int          DEPTH     = WIDTH * HEIGHT;
    localparam logic [7:0]  X_LIMIT   = 8'(WIDTH);
    localparam logic [6:0]  Y_LIMIT   = 7'(HEIGHT);
    localparam logic [7:0]  X_LAST    = 8'(WIDTH - 1);
    localparam logic [6:0]  Y_LAST    = 7'(HEIGHT - 1);
    localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);

    function automatic logic [14:0] f_addr(input logic [7:0] x, input logic [6:0] y);
        if (WIDTH == 160)
            return 15'({y, 7'b0}) + 15'({y, 5'b0}) + 15'(x);
        else
            return 15'(int'(y) * WIDTH + int'(x));
    endfunction

    logic [2:0]  r_mem [0:DEPTH-1];

    logic        w_wr_ok;
    logic        w_rd_ok;
    logic [14:0] w_wr_addr;
    logic [14:0] w_rd_addr;
    logic        w_we;
    logic [14:0] w_waddr;
    logic [2:0]  w_wdata;
    logic        w_rd_block;

    assign w_wr_ok   = (x_in < X_LIMIT) && (y_in < Y_LIMIT);
    assign w_rd_ok   = (rd_x < X_LIMIT) && (rd_y < Y_LIMIT);
    assign w_wr_addr = f_addr(x_in, y_in);
    assign w_rd_addr = f_addr(rd_x, rd_y);

`ifdef FB_CLEAR_EN
    logic        r_clr_busy;
    logic        r_clr_done;
    logic [14:0] r_clr_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
            r_clr_addr <= '0;
        end else begin
            r_clr_done <= 1'b0;
            if (r_clr_busy) begin
                if (r_clr_addr == LAST_ADDR) begin
                    r_clr_busy <= 1'b0;
                    r_clr_done <= 1'b1;
                end else begin
                    r_clr_addr <= r_clr_addr + 15'd1;
                end
            end else if (clear_req) begin
                r_clr_busy <= 1'b1;
                r_clr_addr <= '0;
            end
        end
    end

    // The clear engine owns the write path; a reset edge must not land one more zero.
    assign w_we       = !rst && (r_clr_busy || (plot && w_wr_ok));
    assign w_waddr    = r_clr_busy ? r_clr_addr : w_wr_addr;
    assign w_wdata    = r_clr_busy ? 3'b000 : colour_in;
    assign w_rd_block = r_clr_busy;
    assign clear_busy = r_clr_busy;
    assign clear_done = r_clr_done;
`else
    assign w_we       = !rst && plot && w_wr_ok;
    assign w_waddr    = w_wr_addr;
    assign w_wdata    = colour_in;
    assign w_rd_block = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    // Lookup port: non-blocking read alongside the write gives read-before-write.
    logic       r_rd_valid;
    logic [2:0] r_rd_colour;
    logic       r_oob;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid  <= 1'b0;
            r_rd_colour <= 3'b000;
            r_oob       <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en && w_rd_ok && !w_rd_block)
                r_rd_colour <= r_mem[w_rd_addr];
            else
                r_rd_colour <= 3'b000;
            if ((plot && !w_wr_ok) || (rd_en && !w_rd_ok))
                r_oob <= 1'b1;
        end
    end

    assign rd_valid  = r_rd_valid;
    assign rd_colour = r_rd_colour;
    assign oob       = r_oob;

    // Scan-out: raster read counter, one read stage, output register and one skid entry.
    typedef enum logic {S_FILL, S_STREAM} scan_state_t;

    scan_state_t r_state;
    logic [7:0]  r_sx;
    logic [6:0]  r_sy;
    logic [14:0] r_saddr;
    logic        r_b_valid;
    logic [7:0]  r_b_x;
    logic [6:0]  r_b_y;
    logic        r_b_sof;
    logic [2:0]  r_b_colour;
    logic        r_scan_valid;
    logic [7:0]  r_scan_x;
    logic [6:0]  r_scan_y;
    logic [2:0]  r_scan_colour;
    logic        r_scan_sof;
    logic        r_skid_valid;
    logic [7:0]  r_skid_x;
    logic [6:0]  r_skid_y;
    logic [2:0]  r_skid_colour;
    logic        r_skid_sof;

    logic        w_xfer;
    logic [1:0]  w_occ;
    logic        w_issue;

    // A read is issued only when its data is guaranteed a slot (output or skid) on arrival.
    assign w_xfer  = r_scan_valid && scan_ready;
    assign w_occ   = 2'(r_scan_valid) + 2'(r_skid_valid) + 2'(r_b_valid);
    assign w_issue = (w_occ - 2'(w_xfer)) < 2'd2;

    always_ff @(posedge clk) begin
        if (w_issue)
            r_b_colour <= r_mem[r_saddr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FILL;
            r_sx          <= '0;
            r_sy          <= '0;
            r_saddr       <= '0;
            r_b_valid     <= 1'b0;
            r_b_x         <= '0;
            r_b_y         <= '0;
            r_b_sof       <= 1'b0;
            r_scan_valid  <= 1'b0;
            r_scan_x      <= '0;
            r_scan_y      <= '0;
            r_scan_colour <= 3'b000;
            r_scan_sof    <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_skid_x      <= '0;
            r_skid_y      <= '0;
            r_skid_colour <= 3'b000;
            r_skid_sof    <= 1'b0;
        end else begin
            r_b_valid <= w_issue;
            if (w_issue) begin
                r_b_x   <= r_sx;
                r_b_y   <= r_sy;
                r_b_sof <= (r_saddr == 15'd0);
                if (r_sx == X_LAST) begin
                    r_sx <= '0;
                    r_sy <= (r_sy == Y_LAST) ? 7'd0 : r_sy + 7'd1;
                end else begin
                    r_sx <= r_sx + 8'd1;
                end
                r_saddr <= (r_saddr == LAST_ADDR) ? 15'd0 : r_saddr + 15'd1;
            end

            unique case (r_state)
                S_FILL: begin
                    if (r_b_valid) begin
                        r_scan_valid  <= 1'b1;
                        r_scan_x      <= r_b_x;
                        r_scan_y      <= r_b_y;
                        r_scan_colour <= r_b_colour;
                        r_scan_sof    <= r_b_sof;
                        r_state       <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (!r_scan_valid || w_xfer) begin
                        if (r_skid_valid) begin
                            r_scan_valid  <= 1'b1;
                            r_scan_x      <= r_skid_x;
                            r_scan_y      <= r_skid_y;
                            r_scan_colour <= r_skid_colour;
                            r_scan_sof    <= r_skid_sof;
                            r_skid_valid  <= r_b_valid;
                            if (r_b_valid) begin
                                r_skid_x      <= r_b_x;
                                r_skid_y      <= r_b_y;
                                r_skid_colour <= r_b_colour;
                                r_skid_sof    <= r_b_sof;
                            end
                        end else if (r_b_valid) begin
                            r_scan_valid  <= 1'b1;
                            r_scan_x      <= r_b_x;
                            r_scan_y      <= r_b_y;
                            r_scan_colour <= r_b_colour;
                            r_scan_sof    <= r_b_sof;
                        end else begin
                            r_scan_valid <= 1'b0;
                        end
                    end else if (r_b_valid) begin
                        r_skid_valid  <= 1'b1;
                        r_skid_x      <= r_b_x;
                        r_skid_y      <= r_b_y;
                        r_skid_colour <= r_b_colour;
                        r_skid_sof    <= r_b_sof;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign scan_valid  = r_scan_valid;
    assign scan_x      = r_scan_x;
    assign scan_y      = r_scan_y;
    assign scan_colour = r_scan_colour;
    assign scan_sof    = r_scan_sof;

endmodule
